// File: rtl/bin_to_bcd_seq_pkg.sv
// rtl/bin_to_bcd_seq_pkg.sv - shared state encodings and sizing helpers for bin_to_bcd_seq
package bin_to_bcd_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  localparam logic [3:0] OVF_DIGIT = 4'hE;

  // Decimal digits needed to hold any in_w-bit unsigned magnitude.
  function automatic int calc_ndig(input int in_w);
    return in_w / 3 + 1;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// rtl/bin_to_bcd_seq_digit_adj.sv - double-dabble digit correction (add 3 when digit >= 5)
module bcd_digit_adj (
  input  logic [3:0] i_d,
  output logic [3:0] o_d
);

  assign o_d = (i_d >= 4'd5) ? (i_d + 4'd3) : i_d;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential 32-bit binary to packed BCD converter, one shift per clock
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int IN_W    = 32,
  parameter int OUT_DIG = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [IN_W-1:0]      value,
  input  logic                 is_signed,
  output logic                 busy,
  output logic                 valid,
  output logic [4*OUT_DIG-1:0] bcd,
  output logic                 neg,
  output logic                 ovf
);

  localparam int NDIG = calc_ndig(IN_W);
  localparam int CW   = $clog2(IN_W + 1);

  state_t              r_state;
  state_t              w_next;
  logic [IN_W-1:0]     r_mag;
  logic [4*NDIG-1:0]   r_acc;
  logic [CW-1:0]       r_cnt;
  logic                r_neg_int;
  logic                r_valid;
  logic [4*OUT_DIG-1:0] r_bcd;
  logic                r_neg;
  logic                r_ovf;

  logic                w_in_neg;
  logic [IN_W-1:0]     w_mag;
  logic [4*NDIG-1:0]   w_adj;
  logic                w_ovf;
  logic                w_last;

  assign w_in_neg = is_signed & value[IN_W-1];
  // Two's-complement negate keeps the most negative input exact as an unsigned magnitude.
  assign w_mag    = w_in_neg ? (~value + IN_W'(1)) : value;
  assign w_ovf    = |r_acc[4*NDIG-1:4*OUT_DIG];
  assign w_last   = (r_cnt == CW'(IN_W - 1));

  for (genvar g = 0; g < NDIG; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_d (r_acc[4*g +: 4]),
      .o_d (w_adj[4*g +: 4])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_next = ST_SHIFT;
      ST_SHIFT:  if (w_last) w_next = ST_FINISH;
      ST_FINISH: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mag     <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_neg_int <= 1'b0;
      r_valid   <= 1'b0;
      r_bcd     <= '0;
      r_neg     <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mag     <= w_mag;
            r_neg_int <= w_in_neg;
            r_acc     <= '0;
            r_cnt     <= '0;
          end
        end
        ST_SHIFT: begin
          r_acc <= {w_adj[4*NDIG-2:0], r_mag[IN_W-1]};
          r_mag <= {r_mag[IN_W-2:0], 1'b0};
          r_cnt <= r_cnt + CW'(1);
        end
        ST_FINISH: begin
          r_ovf   <= w_ovf;
          r_bcd   <= w_ovf ? {OUT_DIG{OVF_DIGIT}} : r_acc[4*OUT_DIG-1:0];
          r_neg   <= r_neg_int;
          r_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign valid = r_valid;
  assign bcd   = r_bcd;
  assign neg   = r_neg;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - randomized self-checking bench for bin_to_bcd_seq against a decimal model
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] value;
  logic        is_signed;
  logic        busy;
  logic        valid;
  logic [31:0] bcd;
  logic        neg;
  logic        ovf;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.IN_W(32), .OUT_DIG(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .value     (value),
    .is_signed (is_signed),
    .busy      (busy),
    .valid     (valid),
    .bcd       (bcd),
    .neg       (neg),
    .ovf       (ovf)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: magnitude by plain arithmetic, digits by repeated division by ten.
  task automatic model(input logic [31:0] v, input logic sgn,
                       output logic [31:0] e_bcd, output logic e_neg, output logic e_ovf);
    longint unsigned m;
    e_neg = sgn && v[31];
    m = e_neg ? (64'h1_0000_0000 - {32'h0, v}) : {32'h0, v};
    e_ovf = (m > 64'd99999999);
    e_bcd = 32'h0;
    if (e_ovf) e_bcd = 32'hEEEEEEEE;
    else
      for (int i = 0; i < 8; i++) begin
        e_bcd[4*i +: 4] = 4'(m % 10);
        m = m / 10;
      end
  endtask

  // Waits for valid, counting rising edges since the accepting edge; -1 if it never comes.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] v, input logic sgn);
    logic [31:0] e_bcd;
    logic        e_neg, e_ovf;
    model(v, sgn, e_bcd, e_neg, e_ovf);
    check({tag, ".bcd"}, 64'(bcd), 64'(e_bcd));
    check({tag, ".neg"}, 64'(neg), 64'(e_neg));
    check({tag, ".ovf"}, 64'(ovf), 64'(e_ovf));
  endtask

  task automatic run_conv(input string tag, input logic [31:0] v, input logic sgn);
    int lat;
    @(negedge clk);
    start = 1'b1; value = v; is_signed = sgn;
    @(posedge clk); #1;
    start = 1'b0; value = $urandom; is_signed = $urandom_range(0, 1);
    check({tag, ".busy"}, 64'(busy), 64'd1);
    wait_valid(lat);
    check({tag, ".lat"}, 64'(lat), 64'd33);
    check_result(tag, v, sgn);
    @(posedge clk); #1;
    check({tag, ".pulse"}, 64'(valid), 64'd0);
  endtask

  initial begin
    int lat;
    int nvalid;
    logic [31:0] v;
    logic        s;

    rst = 1'b1; start = 1'b0; value = '0; is_signed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy",  64'(busy),  64'd0);
    check("rst.valid", 64'(valid), 64'd0);
    check("rst.bcd",   64'(bcd),   64'd0);
    check("rst.neg",   64'(neg),   64'd0);
    check("rst.ovf",   64'(ovf),   64'd0);
    @(negedge clk); rst = 1'b0;

    run_conv("u12345678", 32'd12345678, 1'b0);
    run_conv("u99999999", 32'd99999999, 1'b0);
    run_conv("u100000000", 32'd100000000, 1'b0);
    run_conv("sFFFFFFFF", 32'hFFFFFFFF, 1'b1);
    run_conv("s80000000", 32'h80000000, 1'b1);
    run_conv("uFFFFFFFF", 32'hFFFFFFFF, 1'b0);
    run_conv("zero", 32'd0, 1'b0);
    run_conv("s_zero", 32'd0, 1'b1);

    // start pulsed mid-conversion is dropped
    @(negedge clk); start = 1'b1; value = 32'd4321; is_signed = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); start = 1'b1; value = 32'd777; is_signed = 1'b0;
    @(negedge clk); start = 1'b0;
    nvalid = 0;
    for (int n = 0; n < 70; n++) begin
      @(posedge clk); #1;
      if (valid) begin
        nvalid++;
        if (nvalid == 1) check_result("ignore", 32'd4321, 1'b0);
      end
    end
    check("ignore.count", 64'(nvalid), 64'd1);

    // start held through the valid cycle starts a second conversion
    @(negedge clk); start = 1'b1; value = 32'd2468; is_signed = 1'b0;
    @(posedge clk); #1;
    wait_valid(lat);
    check("b2b.lat1", 64'(lat), 64'd33);
    check_result("b2b1", 32'd2468, 1'b0);
    value = 32'hFFFFFF85; is_signed = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b.busy", 64'(busy), 64'd1);
    wait_valid(lat);
    check("b2b.lat2", 64'(lat), 64'd33);
    check_result("b2b2", 32'hFFFFFF85, 1'b1);

    // reset in the middle of a conversion aborts it
    run_conv("pre_rst", 32'hFFFFFF9C, 1'b1);
    @(negedge clk); start = 1'b1; value = 32'd55555; is_signed = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("abort.busy", 64'(busy), 64'd0);
    check("abort.bcd",  64'(bcd),  64'd0);
    check("abort.neg",  64'(neg),  64'd0);
    check("abort.ovf",  64'(ovf),  64'd0);
    @(negedge clk); rst = 1'b0;
    nvalid = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (valid) nvalid++;
    end
    check("abort.novalid", 64'(nvalid), 64'd0);

    // random magnitudes: half kept in display range, half full 32-bit
    for (int i = 0; i < 240; i++) begin
      s = 1'($urandom_range(0, 1));
      v = $urandom_range(0, 1) ? ($urandom % 32'd100000000) : $urandom;
      if (s && $urandom_range(0, 1)) v = -v;
      run_conv(s ? "rnd_s" : "rnd_u", v, s);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
